// File: rtl/dct_sched_pkg.sv
// Shared types and helpers for the DCT block scheduler: width helpers,
// tag/grant types and the round-robin search.
package dct_sched_pkg;

    localparam int unsigned MAX_REQ   = 8;
    localparam int          TAG_MAX_W = 3;

    typedef logic [TAG_MAX_W-1:0] tag_t;

    typedef struct packed {
        logic found;
        tag_t idx;
    } grant_t;

    function automatic int blk_w(input int in_w);
        return 64 * in_w;
    endfunction

    function automatic int tag_w(input int n_req);
        return (n_req > 2) ? $clog2(n_req) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // First set bit of valid scanning upward from ptr+1, wrapping modulo n.
    function automatic grant_t next_grant(input logic [MAX_REQ-1:0] valid,
                                          input tag_t ptr,
                                          input int unsigned n);
        grant_t g;
        tag_t   idx;
        g = '0;
        for (int unsigned i = 1; i <= MAX_REQ; i++) begin
            idx = tag_t'((32'(ptr) + i) % n);
            if (i <= n && !g.found && valid[idx]) begin
                g.found = 1'b1;
                g.idx   = idx;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/dct_block_scheduler_tag_fifo.sv
// In-order FIFO of requester tags for blocks issued to the core but not yet
// returned; the head tag steers the next core result.
module dct_tag_fifo
    import dct_sched_pkg::*;
#(
    parameter int TAG_W = 2,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [TAG_W-1:0]             push_tag,
    input  logic                         pop,
    output logic [TAG_W-1:0]             head_tag,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [TAG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_tag = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Tag storage carries no reset; occupancy alone qualifies it.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_tag;
    end

endmodule

// File: rtl/dct_block_scheduler.sv
// Round-robin sharing of one 8x8 2-D DCT core among N_REQ block requesters,
// with an in-order tag FIFO routing core results back to their owners.
module dct_block_scheduler
    import dct_sched_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int IN_W      = 32,
    parameter int TAG_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_REQ-1:0]                 req_valid,
    output logic [N_REQ-1:0]                 req_ready,
    input  logic [N_REQ*64*IN_W-1:0]         req_data,
    output logic                             core_in_valid,
    input  logic                             core_in_ready,
    output logic [64*IN_W-1:0]               core_in_data,
    input  logic                             core_out_valid,
    output logic                             core_out_ready,
    input  logic [64*IN_W-1:0]               core_out_data,
    output logic [N_REQ-1:0]                 rsp_valid,
    input  logic [N_REQ-1:0]                 rsp_ready,
    output logic [64*IN_W-1:0]               rsp_data,
    output logic [$clog2(TAG_DEPTH+1)-1:0]   outstanding,
    output logic                             busy,
    output logic                             err
);

    localparam int BLK_W = blk_w(IN_W);
    localparam int TAG_W = tag_w(N_REQ);
    localparam int CNT_W = cnt_w(TAG_DEPTH);

    typedef logic [TAG_W-1:0] req_tag_t;

    logic              vld_p1;
    logic [BLK_W-1:0]  data_p1;
    req_tag_t          rr;
    grant_t            gnt;
    req_tag_t          gnt_idx;
    logic              gnt_unused;
    logic              slot_free;
    logic              grant_en;
    logic              accept;
    logic              pop;
    req_tag_t          head_tag;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    // Arbitration: a pop in the same cycle does not free a credit.
    always_comb begin
        gnt       = next_grant(MAX_REQ'(req_valid), tag_t'(rr), N_REQ);
        gnt_idx   = gnt.idx[TAG_W-1:0];
        slot_free = !vld_p1 || core_in_ready;
        grant_en  = slot_free && !fifo_full && gnt.found;
        req_ready = grant_en ? (N_REQ'(1) << gnt_idx) : '0;
        accept    = |(req_valid & req_ready);
    end

    assign gnt_unused = ^gnt.idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            rr     <= TAG_W'(N_REQ - 1);
            err    <= 1'b0;
        end else begin
            if (accept) begin
                vld_p1 <= 1'b1;
                rr     <= gnt_idx;
            end else if (core_in_ready) begin
                vld_p1 <= 1'b0;
            end
            if (core_out_valid && fifo_empty) err <= 1'b1;
        end
    end

    // Issue stage p1: held stable until the core takes it.
    always_ff @(posedge clk) begin
        if (accept) data_p1 <= req_data[gnt_idx*BLK_W +: BLK_W];
    end

    assign core_in_valid = vld_p1;
    assign core_in_data  = data_p1;

    dct_tag_fifo #(
        .TAG_W (TAG_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (accept),
        .push_tag (gnt_idx),
        .pop      (pop),
        .head_tag (head_tag),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Return path: combinational steering by the head tag.
    always_comb begin
        rsp_valid      = (core_out_valid && !fifo_empty) ? (N_REQ'(1) << head_tag) : '0;
        core_out_ready = !fifo_empty && rsp_ready[head_tag];
        pop            = core_out_valid && core_out_ready;
    end

    assign rsp_data    = core_out_data;
    assign outstanding = fifo_count;
    assign busy        = (fifo_count != '0) || vld_p1;

endmodule

// File: doc/dct_block_scheduler.md
Name: dct_block_scheduler

Overview:
- Shares one 8×8 2-D DCT core among N_REQ block requesters (e.g. Y, Cb, Cr channels).
- Round-robin grants one 64-point block per cycle into a registered issue stage, then drives the core input handshake.
- Records each accepted requester ID in an in-order tag FIFO and uses it to steer core results back to the originating requester.
- Sits between the per-channel block buffers and the 2-D DCT core; the core itself is instantiated by the parent.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- IN_W, 32, bits per coefficient; one block = 64*IN_W bits.
- TAG_DEPTH, 4, maximum blocks accepted but not yet returned (power of 2, ≥2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester block valid
- req_ready  out  N_REQ  per-requester accept; one-hot or zero
- req_data  in  N_REQ*64*IN_W  requester r occupies slice [r*64*IN_W +: 64*IN_W]
- core_in_valid  out  1  block valid to core
- core_in_ready  in  1  core accepts block
- core_in_data  out  64*IN_W  block to core
- core_out_valid  in  1  core result valid
- core_out_ready  out  1  result accepted
- core_out_data  in  64*IN_W  core result
- rsp_valid  out  N_REQ  result valid for requester r
- rsp_ready  in  N_REQ  requester r accepts result
- rsp_data  out  64*IN_W  core_out_data broadcast to all requesters
- outstanding  out  $clog2(TAG_DEPTH+1)  tag FIFO occupancy
- busy  out  1  outstanding!=0 or hold register full
- err  out  1  sticky protocol error

Behaviour:
- Reset (async, rst_n=0): hold register empty; core_in_valid=0; tag FIFO empty; outstanding=0; rr pointer=N_REQ-1; err=0; busy=0; req_ready=0; rsp_valid=0; core_out_ready=0. core_in_data is don't-care.
- Issue slot free: hold empty, or (core_in_valid & core_in_ready) this cycle.
- Credit available: outstanding<TAG_DEPTH. A pop in the same cycle does not free a credit.
- Arbitration, when slot free and credit available:
  - Scan requesters starting at rr+1 (mod N_REQ); the first with req_valid set is granted g.
  - req_ready[g]=1 combinationally. req_ready depends on req_valid; requesters must not make valid depend on ready.
- Grant handshake (req_valid[g] & req_ready[g]):
  - Hold register <= req_data slice g.
  - Tag g pushed into FIFO.
  - rr <= g.
- Issue latency: accepted at cycle t, core_in_valid=1 at t+1. Sustained throughput is 1 block/cycle when the core is always ready.
- Hold stays valid with stable data until core_in_ready. core_in_valid never drops without a handshake.
- Return path, with head tag h:
  - rsp_valid[h] = core_out_valid & FIFO non-empty; all other rsp_valid bits are 0.
  - core_out_ready = FIFO non-empty & rsp_ready[h].
  - Pop on core_out_valid & core_out_ready.
  - Zero added latency (combinational pass-through).
- Simultaneous push and pop (only when not full): occupancy unchanged.
- Full (outstanding==TAG_DEPTH): req_ready all 0; a hold already loaded still issues to the core.
- core_out_valid while FIFO empty: err<=1 (sticky until reset); data discarded, core_out_ready=0.
- Reset mid-operation: all state cleared. The core shares rst_n, so in-flight blocks are discarded; no results are delivered after reset.
- The core returns results in issue order; ordering is guaranteed by the FIFO discipline only.

Decomposition:
- Package dct_sched_pkg:
  - BLK_W=64*IN_W
  - function clog2-based widths
  - tag type logic [$clog2(N_REQ)-1:0]
  - rr-search function next_grant(valid, ptr)
- Sub-module dct_tag_fifo: synchronous FIFO of tags with count, full and empty outputs, reset to empty.

Test Plan:
- Single requester, core always ready: req 1 sends blocks A, B on consecutive cycles.
  -> core_in_valid at t+1 and t+2 with A, B.
  -> results return as rsp_valid=3'b010 twice, in order; outstanding peaks at 2.
- All three requesters valid continuously, core ready.
  -> grant sequence 0,1,2,0,1,2; rsp_valid order matches.
- Core result stalled (core_out_valid=0), TAG_DEPTH=4, six requests pending.
  -> exactly 4 accepted, then req_ready=0 and outstanding=4.
  -> after one result is popped, one grant on the following cycle.
- Head tag=2 with rsp_ready[2]=0 for 5 cycles, core_out_valid=1.
  -> core_out_ready=0 and rsp_valid=3'b100 held for 5 cycles.
  -> pop on the cycle rsp_ready[2] rises; rsp_data stable throughout.
- core_out_valid=1 with empty FIFO.
  -> err=1 next cycle and stays 1; rsp_valid stays 0.
- rst_n asserted with outstanding=3 and hold full.
  -> immediately outstanding=0, core_in_valid=0, busy=0.
  -> after release, the first grant goes to requester 0.
